// File: rtl/plot_frame_capture.sv
// Frame-capture sink for the pixel-plot interface: stores every plotted pixel
// and, on request, streams the whole frame out in raster order while counting matches.
module plot_frame_capture #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int XW     = 8,
    parameter int YW     = 7,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] vga_x,
    input  logic [YW-1:0] vga_y,
    input  logic [CW-1:0] vga_colour,
    input  logic          vga_plot,
    input  logic          start,
    input  logic [CW-1:0] cmp_colour,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [CW-1:0] out_colour,
    output logic [14:0]   match_count
);

    localparam int AW    = 15;
    localparam int DEPTH = WIDTH * HEIGHT;

    localparam logic [XW:0]   X_LIM = (XW+1)'(WIDTH);
    localparam logic [YW:0]   Y_LIM = (YW+1)'(HEIGHT);
    localparam logic [XW-1:0] X_END = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_END = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PRESENT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0] frame [DEPTH];
    logic [CW-1:0] rd_data;
    logic [CW-1:0] cmp_latched;
    logic [XW-1:0] ptr_x;
    logic [YW-1:0] ptr_y;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic          scan_start;
    logic          load;
    logic          accept;
    logic          last_pixel;

    always_comb begin
        wr_en      = vga_plot && ({1'b0, vga_x} < X_LIM) && ({1'b0, vga_y} < Y_LIM);
        wr_addr    = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
        rd_addr    = AW'(ptr_y) * AW'(WIDTH) + AW'(ptr_x);
        last_pixel = (ptr_x == X_END) && (ptr_y == Y_END);
    end

    // Plain RAM with no reset; a same-cycle read of a written address sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            frame[wr_addr] <= vga_colour;
        end
        if (state == READ) begin
            rd_data <= frame[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        scan_start = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    scan_start = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                state_next = PRESENT;
            end
            PRESENT: begin
                // out_valid is always low on entry, so its low phase marks the load cycle.
                if (!out_valid) begin
                    load = 1'b1;
                end else if (out_ready) begin
                    accept     = 1'b1;
                    state_next = last_pixel ? DONE : READ;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_colour  <= '0;
            match_count <= '0;
            ptr_x       <= '0;
            ptr_y       <= '0;
            cmp_latched <= '0;
        end else begin
            done <= (state == DONE);
            if (scan_start) begin
                cmp_latched <= cmp_colour;
                match_count <= '0;
                ptr_x       <= '0;
                ptr_y       <= '0;
            end
            if (load) begin
                out_valid  <= 1'b1;
                out_colour <= rd_data;
                out_x      <= ptr_x;
                out_y      <= ptr_y;
            end
            if (accept) begin
                out_valid <= 1'b0;
                if (out_colour == cmp_latched) begin
                    match_count <= match_count + 15'(1);
                end
                if (ptr_x == X_END) begin
                    ptr_x <= '0;
                    ptr_y <= ptr_y + YW'(1);
                end else begin
                    ptr_x <= ptr_x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_plot_frame_capture.sv
// Scoreboard bench for plot_frame_capture: a flat frame model predicts every
// streamed beat, the match count and the valid/done timing.
module tb_plot_frame_capture;

    localparam int W    = 40;
    localparam int H    = 30;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 3;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [XW-1:0] vga_x = '0;
    logic [YW-1:0] vga_y = '0;
    logic [CW-1:0] vga_colour = '0;
    logic          vga_plot = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cmp_colour = '0;
    logic          done;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [CW-1:0] out_colour;
    logic [14:0]   match_count;

    plot_frame_capture #(
        .WIDTH (W),
        .HEIGHT(H),
        .XW    (XW),
        .YW    (YW),
        .CW    (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .start      (start),
        .cmp_colour (cmp_colour),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } beat_t;

    beat_t exp_q[$];
    int    model_frame [NPIX];
    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    int    extra_beats = 0;
    int    expect_rise_edge = -1;
    int    expect_done_edge = -1;
    bit    prev_valid = 1'b0;
    bit    prev_done = 1'b0;
    bit    stalled = 1'b0;
    beat_t held;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops one expected beat per handshake and checks valid/done timing.
    always @(negedge clk) begin
        beat_t got;
        beat_t e;
        if (!rst_n) begin
            stalled    = 1'b0;
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            got = {out_x, out_y, out_colour};
            if (out_valid && !prev_valid) check("valid_latency", cyc, expect_rise_edge);
            if (done && !prev_done) check("done_latency", cyc, expect_done_edge);
            if (stalled && out_valid) check("stall_hold", int'(got), int'(held));
            stalled = 1'b0;
            if (out_valid && !out_ready) begin
                stalled = 1'b1;
                held    = got;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    extra_beats++;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d", beats_seen), int'(got), int'(e));
                    if (exp_q.size() == 0) expect_done_edge = cyc + 2;
                    beats_seen++;
                end
                expect_rise_edge = cyc + 3;
            end
            prev_valid = out_valid;
            prev_done  = done;
        end
    end

    task automatic model_write(input int x, input int y, input int c);
        if (x >= 0 && x < W && y >= 0 && y < H) model_frame[y * W + x] = c;
    endtask

    task automatic plot_one(input int x, input int y, input int c);
        vga_x      = XW'(x);
        vga_y      = YW'(y);
        vga_colour = CW'(c);
        vga_plot   = 1'b1;
        model_write(x, y, c);
        @(posedge clk); #1;
        vga_plot = 1'b0;
    endtask

    task automatic fill(input bit random_colour, input int c);
        int col;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                col        = random_colour ? int'($urandom_range(0, 7)) : c;
                vga_x      = XW'(x);
                vga_y      = YW'(y);
                vga_colour = CW'(col);
                vga_plot   = 1'b1;
                model_write(x, y, col);
                @(posedge clk); #1;
            end
        end
        vga_plot = 1'b0;
    endtask

    task automatic begin_scan(input int cmp, output int exp_match);
        beat_t b;
        exp_match = 0;
        exp_q.delete();
        extra_beats = 0;
        beats_seen  = 0;
        for (int i = 0; i < NPIX; i++) begin
            b.x = XW'(i % W);
            b.y = YW'(i / W);
            b.c = CW'(model_frame[i]);
            exp_q.push_back(b);
            if (model_frame[i] == cmp) exp_match++;
        end
        cmp_colour       = CW'(cmp);
        start            = 1'b1;
        expect_rise_edge = cyc + 3;
    endtask

    task automatic run_scan(input int cmp, input bit rand_ready, input bit drop_start, input bit collide);
        int exp_match;
        int phase = 0;
        bit seen_done = 1'b0;
        begin_scan(cmp, exp_match);
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 0; k < NPIX * 8 + 100 && !seen_done; k++) begin
            @(posedge clk); #1;
            cmp_colour = CW'($urandom);
            if (drop_start && k == 10) start = 1'b0;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (collide) begin
                if (phase == 2) begin
                    vga_plot = 1'b0;
                    phase    = 3;
                end else if (phase == 1) begin
                    vga_x      = XW'(W - 1);
                    vga_y      = YW'(H - 1);
                    vga_colour = 3'd7;
                    vga_plot   = 1'b1;
                    model_write(W - 1, H - 1, 7);
                    phase = 2;
                end else if (phase == 0 && out_valid && out_x == XW'(W - 2) && out_y == YW'(H - 1)) begin
                    phase = 1;
                end
            end
            if (done) seen_done = 1'b1;
        end
        vga_plot = 1'b0;
        if (!seen_done) check("scan_done_timeout", int'(done), 1);
        check("match_count", int'(match_count), exp_match);
        check("beats_left", exp_q.size(), 0);
        check("extra_beats", extra_beats, 0);
        if (drop_start) begin
            @(posedge clk); #1;
            check("done_pulse_end", int'(done), 0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check("done_held", int'(done), 1);
                check("valid_idle", int'(out_valid), 0);
            end
            start = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("done_cleared", int'(done), 0);
        end
        check("match_count_hold", int'(match_count), exp_match);
    endtask

    task automatic reset_mid_scan(input int at_beat);
        int exp_match;
        begin_scan(model_frame[0], exp_match);
        out_ready = 1'b1;
        for (int k = 0; k < NPIX * 8 && beats_seen < at_beat; k++) begin
            @(posedge clk); #1;
        end
        check("reached_mid_scan", beats_seen, at_beat);
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_match_count", int'(match_count), 0);
        check("rst_out_x", int'(out_x), 0);
        exp_q.delete();
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) model_frame[i] = 0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_done", int'(done), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_x", int'(out_x), 0);
        check("reset_out_y", int'(out_y), 0);
        check("reset_out_colour", int'(out_colour), 0);
        check("reset_match_count", int'(match_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        fill(1'b0, 2);
        run_scan(2, 1'b0, 1'b0, 1'b0);

        fill(1'b0, 0);
        plot_one(5, 7, 5);
        run_scan(5, 1'b0, 1'b0, 1'b0);

        plot_one(W, 0, 7);
        plot_one(0, H, 7);
        plot_one(255, 127, 7);
        run_scan(7, 1'b0, 1'b0, 1'b0);

        fill(1'b1, 0);
        run_scan(int'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);

        fill(1'b0, 1);
        run_scan(1, 1'b0, 1'b0, 1'b1);
        run_scan(7, 1'b0, 1'b0, 1'b0);

        fill(1'b1, 0);
        run_scan(int'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0);

        reset_mid_scan(500);
        run_scan(int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
